// File: rtl/uart_apb_cmd_decoder.sv
// Byte-level UART command decoder feeding an APB master request port.
// Assembles read/write frames, issues one start pulse, and serialises the response back out.
module uart_apb_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        write_en,
  output logic        start,
  output logic        ready,
  input  logic [31:0] rdata,
  input  logic        done,
  output logic        busy,
  output logic        rx_overrun
);

  // state  | meaning
  // IDLE   | waiting for a command byte
  // ADDR   | shifting in 4 address bytes
  // DATA   | shifting in 4 write-data bytes
  // ISSUE  | one-cycle start pulse to the APB master
  // WAIT   | waiting for done from the APB master
  // RESP   | sending response bytes to the UART transmitter
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] RSP_ACK   = 8'h4B;

  state_t      state, state_nx;
  logic [1:0]  byte_cnt;
  logic [31:0] timer;
  logic [23:0] resp_shift;
  logic [1:0]  resp_left;
  logic        timeout_hit, tx_fire, last_byte;
  logic        start_nx, ready_nx, busy_nx, tx_valid_nx, overrun_nx;

  assign tx_fire   = tx_valid && tx_ready;
  assign last_byte = rx_valid && (byte_cnt == 2'd3);
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && !rx_valid &&
                       ((timer + 32'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) state_nx = S_ADDR;
          else                                             state_nx = S_RESP;
        end
      S_ADDR:
        if (timeout_hit)    state_nx = S_IDLE;
        else if (last_byte) state_nx = write_en ? S_DATA : S_ISSUE;
      S_DATA:
        if (timeout_hit)    state_nx = S_IDLE;
        else if (last_byte) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (done) state_nx = S_RESP;
      S_RESP:  if (tx_fire && resp_left == 2'd0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Flags are decoded from the next state so the registered outputs line up with the state.
  always_comb begin
    start_nx    = (state_nx == S_ISSUE);
    ready_nx    = (state_nx == S_WAIT);
    busy_nx     = (state_nx != S_IDLE);
    tx_valid_nx = (state_nx == S_RESP);
    overrun_nx  = rx_valid && (state == S_ISSUE || state == S_WAIT || state == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start      <= 1'b0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      tx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      start      <= start_nx;
      ready      <= ready_nx;
      busy       <= busy_nx;
      tx_valid   <= tx_valid_nx;
      rx_overrun <= overrun_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= 2'd0;
      timer      <= 32'd0;
      addr       <= 32'd0;
      wdata      <= 32'd0;
      write_en   <= 1'b0;
      tx_data    <= 8'd0;
      resp_shift <= 24'd0;
      resp_left  <= 2'd0;
    end else begin
      if (state == S_ADDR || state == S_DATA) begin
        if (rx_valid || timeout_hit) timer <= 32'd0;
        else                         timer <= timer + 32'd1;
        if (timeout_hit)   byte_cnt <= 2'd0;
        else if (rx_valid) byte_cnt <= byte_cnt + 2'd1;
      end else begin
        timer    <= 32'd0;
        byte_cnt <= 2'd0;
      end

      if (state == S_ADDR && rx_valid) addr  <= {addr[23:0], rx_data};
      if (state == S_DATA && rx_valid) wdata <= {wdata[23:0], rx_data};

      case (state)
        S_IDLE:
          if (rx_valid) begin
            if (rx_data == CMD_WRITE)     write_en <= 1'b1;
            else if (rx_data == CMD_READ) write_en <= 1'b0;
            else begin
              tx_data   <= RSP_ERR;
              resp_left <= 2'd0;
            end
          end
        S_WAIT:
          if (done) begin
            if (write_en) begin
              tx_data   <= RSP_ACK;
              resp_left <= 2'd0;
            end else begin
              tx_data    <= rdata[31:24];
              resp_shift <= rdata[23:0];
              resp_left  <= 2'd3;
            end
          end
        S_RESP:
          if (tx_fire && resp_left != 2'd0) begin
            tx_data    <= resp_shift[23:16];
            resp_shift <= {resp_shift[15:0], 8'd0};
            resp_left  <= resp_left - 2'd1;
          end
        default: ;
      endcase
    end
  end

endmodule
